// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: fetch-prediction, flag-write and resolve signals of the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int OPW = 6,
    parameter int PCW = 32,
    parameter int STAT_W = 16
);
    logic flag_we;
    logic fZero_in;
    logic fSign_in;
    logic fCarry_in;
    logic [PCW-1:0] fetch_pc;
    logic [OPW-1:0] fetch_opcode;
    logic pred_taken;
    logic res_valid;
    logic [OPW-1:0] res_opcode;
    logic [PCW-1:0] res_pc;
    logic [PCW-1:0] res_target;
    logic res_pred;
    logic redirect;
    logic [PCW-1:0] redirect_pc;
    logic res_taken;
    logic [2:0] flags_q;
    logic [STAT_W-1:0] n_branch;
    logic [STAT_W-1:0] n_mispred;
    modport master (
        output flag_we, fZero_in, fSign_in, fCarry_in, fetch_pc, fetch_opcode,
               res_valid, res_opcode, res_pc, res_target, res_pred,
        input  pred_taken, redirect, redirect_pc, res_taken, flags_q, n_branch, n_mispred
    );
    modport slave (
        input  flag_we, fZero_in, fSign_in, fCarry_in, fetch_pc, fetch_opcode,
               res_valid, res_opcode, res_pc, res_target, res_pred,
        output pred_taken, redirect, redirect_pc, res_taken, flags_q, n_branch, n_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: flag register, saturating-counter direction predictor and execute-stage branch resolver
module branch_resolve_unit #(
    parameter int OPW = 6,
    parameter int PCW = 32,
    parameter int BHT_DEPTH = 16,
    parameter int CTR_W = 2,
    parameter int STAT_W = 16
) (
    input logic clk,
    input logic rst,
    branch_resolve_unit_if.slave bus
);
    localparam int IDXW = $clog2(BHT_DEPTH);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [OPW-1:0] OP_J = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_JL = OPW'(6'b101000);
    localparam logic [OPW-1:0] OP_BZ = OPW'(6'b110001);
    localparam logic [OPW-1:0] OP_BNZ = OPW'(6'b110010);
    localparam logic [OPW-1:0] OP_BLTZ = OPW'(6'b110000);
    localparam logic [OPW-1:0] OP_BCY = OPW'(6'b101001);
    localparam logic [OPW-1:0] OP_BNCY = OPW'(6'b101010);

    function automatic logic isUncond(input logic [OPW-1:0] op);
        return op == OP_J || op == OP_JL;
    endfunction

    function automatic logic isCond(input logic [OPW-1:0] op);
        return op == OP_BZ || op == OP_BNZ || op == OP_BLTZ || op == OP_BCY || op == OP_BNCY;
    endfunction

    logic [CTR_W-1:0] bht [BHT_DEPTH];
    logic [2:0] flagsQ;
    logic redirectQ, resTakenQ;
    logic [PCW-1:0] redirectPcQ;
    logic [STAT_W-1:0] nBranchQ, nMispredQ;
    logic [IDXW-1:0] fetchIdx, resIdx;
    logic curZero, curSign, curCarry;
    logic resUncond, resCond, resBranch, taken, mispred;
    logic [CTR_W-1:0] ctrOld, ctrNext;

    assign fetchIdx = bus.fetch_pc[2 +: IDXW];
    assign resIdx = bus.res_pc[2 +: IDXW];
    assign bus.pred_taken = isUncond(bus.fetch_opcode) ? 1'b1 :
                            isCond(bus.fetch_opcode) ? bht[fetchIdx][CTR_W-1] : 1'b0;

    // Same-cycle ALU flags bypass the register so a branch right behind its compare resolves correctly
    always_comb begin
        curZero = bus.flag_we && bus.res_valid ? bus.fZero_in : flagsQ[0];
        curSign = bus.flag_we && bus.res_valid ? bus.fSign_in : flagsQ[1];
        curCarry = bus.flag_we && bus.res_valid ? bus.fCarry_in : flagsQ[2];
        resUncond = isUncond(bus.res_opcode);
        resCond = bus.res_valid && isCond(bus.res_opcode);
        resBranch = bus.res_valid && (resUncond || isCond(bus.res_opcode));
        taken = resUncond ||
                (bus.res_opcode == OP_BZ && curZero) ||
                (bus.res_opcode == OP_BNZ && !curZero) ||
                (bus.res_opcode == OP_BLTZ && curSign) ||
                (bus.res_opcode == OP_BCY && curCarry) ||
                (bus.res_opcode == OP_BNCY && !curCarry);
        mispred = taken != bus.res_pred;
        ctrOld = bht[resIdx];
        ctrNext = taken ? (ctrOld == CTR_MAX ? ctrOld : ctrOld + 1'b1) :
                          (ctrOld == '0 ? ctrOld : ctrOld - 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CTR_INIT;
            flagsQ <= '0;
            redirectQ <= 1'b0;
            resTakenQ <= 1'b0;
            redirectPcQ <= '0;
            nBranchQ <= '0;
            nMispredQ <= '0;
        end else begin
            if (bus.flag_we) flagsQ <= {bus.fCarry_in, bus.fSign_in, bus.fZero_in};
            redirectQ <= resBranch && mispred;
            resTakenQ <= resBranch && taken;
            if (resBranch) begin
                redirectPcQ <= taken ? bus.res_target : bus.res_pc + PCW'(4);
                nBranchQ <= nBranchQ + 1'b1;
                if (mispred) nMispredQ <= nMispredQ + 1'b1;
            end
            if (resCond) bht[resIdx] <= ctrNext;
        end
    end

    assign bus.flags_q = flagsQ;
    assign bus.redirect = redirectQ;
    assign bus.redirect_pc = redirectPcQ;
    assign bus.res_taken = resTakenQ;
    assign bus.n_branch = nBranchQ;
    assign bus.n_mispred = nMispredQ;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed plus random stimulus, reference model feeding a scoreboard queue
module tb_branch_resolve_unit;
    localparam logic [5:0] J = 6'b101011, JL = 6'b101000, BZ = 6'b110001, BNZ = 6'b110010;
    localparam logic [5:0] BLTZ = 6'b110000, BCY = 6'b101001, BNCY = 6'b101010, NOP = 6'b000000;

    typedef struct {
        logic redirect;
        logic [31:0] rpc;
        logic taken;
        logic [2:0] flags;
        logic [15:0] nb;
        logic [15:0] nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int total = 0;
    int passed = 0;
    exp_t q[$];

    int ctr[16];
    bit mz, ms, mc;
    int nb, nm;
    logic [31:0] rpcM;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.OPW(6), .PCW(32), .STAT_W(16)) bus ();
    branch_resolve_unit dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    endtask

    function automatic bit uncondOp(input logic [5:0] op);
        return op == J || op == JL;
    endfunction

    function automatic bit condOp(input logic [5:0] op);
        return op == BZ || op == BNZ || op == BLTZ || op == BCY || op == BNCY;
    endfunction

    task automatic step(input bit r, input bit fwe, input bit z, input bit s, input bit c,
                        input logic [31:0] fpc, input logic [5:0] fop, input bit rv,
                        input logic [5:0] rop, input logic [31:0] rpc, input logic [31:0] tgt,
                        input bit rp);
        bit cz, cs, cc, br, tk;
        int idx;
        exp_t e;
        rst = r;
        bus.flag_we = fwe; bus.fZero_in = z; bus.fSign_in = s; bus.fCarry_in = c;
        bus.fetch_pc = fpc; bus.fetch_opcode = fop;
        bus.res_valid = rv; bus.res_opcode = rop; bus.res_pc = rpc;
        bus.res_target = tgt; bus.res_pred = rp;
        #1;
        if (!r) chk("pred_taken", 32'(bus.pred_taken),
                    32'(uncondOp(fop) || (condOp(fop) && ctr[fpc[5:2]] >= 2)));
        if (r) begin
            foreach (ctr[i]) ctr[i] = 1;
            {mc, ms, mz} = 3'b000;
            nb = 0; nm = 0; rpcM = '0;
            e = '{1'b0, 32'h0, 1'b0, 3'b000, 16'h0, 16'h0};
        end else begin
            cz = fwe ? z : mz; cs = fwe ? s : ms; cc = fwe ? c : mc;
            br = rv && (uncondOp(rop) || condOp(rop));
            tk = uncondOp(rop) || (rop == BZ && cz) || (rop == BNZ && !cz) ||
                 (rop == BLTZ && cs) || (rop == BCY && cc) || (rop == BNCY && !cc);
            if (br) begin
                rpcM = tk ? tgt : rpc + 32'd4;
                nb = (nb + 1) % 65536;
                if (tk != rp) nm = (nm + 1) % 65536;
                if (condOp(rop)) begin
                    idx = int'(rpc[5:2]);
                    ctr[idx] = tk ? (ctr[idx] < 3 ? ctr[idx] + 1 : 3) : (ctr[idx] > 0 ? ctr[idx] - 1 : 0);
                end
            end
            if (fwe) {mc, ms, mz} = {c, s, z};
            e = '{br && tk != rp, rpcM, br && tk, {mc, ms, mz}, 16'(nb), 16'(nm)};
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("redirect", 32'(bus.redirect), 32'(e.redirect));
            chk("redirect_pc", bus.redirect_pc, e.rpc);
            chk("res_taken", 32'(bus.res_taken), 32'(e.taken));
            chk("flags_q", 32'(bus.flags_q), 32'(e.flags));
            chk("n_branch", 32'(bus.n_branch), 32'(e.nb));
            chk("n_mispred", 32'(bus.n_mispred), 32'(e.nm));
        end
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] rop;
        ops = '{J, JL, BZ, BNZ, BLTZ, BCY, BNCY, NOP};
        step(1, 0, 0, 0, 0, 0, NOP, 0, NOP, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, NOP, 0, NOP, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h40, BZ, 0, NOP, 0, 0, 0);
        step(0, 1, 1, 0, 0, 32'h40, BZ, 0, NOP, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h40, BZ, 1, BZ, 32'h40, 32'h100, 0);
        step(0, 0, 0, 0, 0, 32'h40, BZ, 0, NOP, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h80, BNCY, 1, BNCY, 32'h80, 32'h200, 1);
        repeat (4) step(0, 0, 0, 0, 0, 32'hC0, BNZ, 1, BNZ, 32'hC0, 32'h300, 1);
        step(0, 1, 1, 0, 0, 32'hC0, BNZ, 1, BNZ, 32'hC0, 32'h300, 1);
        step(0, 0, 0, 0, 0, 32'hC0, BNZ, 0, NOP, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'h40, J, 1, J, 32'h40, 32'h500, 1);
        step(0, 0, 0, 0, 0, 32'h40, BZ, 1, NOP, 32'h44, 32'h600, 1);
        step(0, 0, 0, 0, 0, 32'h48, JL, 1, J, 32'h48, 32'h700, 0);
        step(1, 0, 0, 0, 0, 32'h40, BZ, 1, BZ, 32'h40, 32'h800, 0);
        step(0, 0, 0, 0, 0, 32'h40, BZ, 0, NOP, 0, 0, 0);
        step(0, 0, 0, 0, 0, 32'hFFFFFFFC, BZ, 1, BZ, 32'hFFFFFFFC, 32'h10, 1);
        for (int i = 0; i < 400; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            step($urandom_range(0, 60) == 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 32'($urandom_range(0, 63)) << 2, ops[$urandom_range(0, 7)],
                 $urandom_range(0, 3) != 0, rop, 32'($urandom_range(0, 63)) << 2,
                 32'($urandom), 1'($urandom));
        end
        bus.res_valid = 1'b0;
        bus.flag_we = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised successor to the combinational branch-condition decoder in KGP-RISC. It holds the architectural Zero/Sign/Carry flag register and predicts branch direction at fetch from a table of saturating counters. It resolves branches in execute against the current flags and issues a registered redirect/flush with the resolved target. It sits between fetch (prediction port) and execute (flag-write and resolve ports).

## Interface
- OPW, 6: opcode width.
- PCW, 32: PC and target width.
- BHT_DEPTH, 16: counter-table entries, power of 2, ≥2; index = pc[2 +: log2(BHT_DEPTH)].
- CTR_W, 2: counter width, ≥1; prediction = counter MSB.
- STAT_W, 16: width of branch and mispredict statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flag_we  in  1  ALU result valid; latch flags.
- fZero_in / fSign_in / fCarry_in  in  1 each  flags from ALU.
- fetch_pc  in  PCW  PC being fetched.
- fetch_opcode  in  OPW  opcode at fetch_pc.
- pred_taken  out  1  combinational prediction for fetch_pc.
- res_valid  in  1  branch in execute this cycle.
- res_opcode  in  OPW  its opcode.
- res_pc  in  PCW  its PC.
- res_target  in  PCW  its taken target.
- res_pred  in  1  prediction it was fetched with.
- redirect  out  1  registered one-cycle pulse on mispredict.
- redirect_pc  out  PCW  correct next PC, valid with redirect.
- res_taken  out  1  registered resolved direction.
- flags_q  out  3  {Carry, Sign, Zero} registered.
- n_branch, n_mispred  out  STAT_W each  statistics.

## Operation
- Opcode classes:
  - Unconditional: 101011 and 101000.
  - bz: 110001 (Zero=1).
  - bnz: 110010 (Zero=0).
  - bltz: 110000 (Sign=1).
  - bcy: 101001 (Carry=1).
  - bncy: 101010 (Carry=0).
  - All other opcodes are non-branches.
- Flags: flag_we=1 loads all three flags at the clock edge; otherwise they hold.
- Condition source: if flag_we and res_valid are both high in the same cycle, the condition uses the *_in flags (bypass); otherwise it uses flags_q.
- Prediction:
  - Unconditional opcode: pred_taken=1.
  - Conditional opcode: pred_taken = MSB of bht[idx(fetch_pc)].
  - Non-branch: pred_taken=0.
  - This path is purely combinational.
- Resolve: when res_valid is high and res_opcode is a branch class:
  - taken = class condition (always 1 for unconditional).
  - mispredict = taken ≠ res_pred.
  - Next edge: res_taken=taken; redirect=mispredict; redirect_pc = taken ? res_target : res_pc+4 (modulo 2^PCW).
  - Conditional class only: bht[idx(res_pc)] increments when taken and decrements otherwise, saturating at 0 and 2^CTR_W−1. Unconditional branches leave the table unchanged.
  - n_branch increments; n_mispred increments on mispredict. Both wrap modulo 2^STAT_W.
- res_valid with a non-branch opcode: no effect. redirect=0, res_taken=0, no table or stats change.
- res_valid=0: redirect and res_taken are 0 next cycle. redirect_pc holds its last value.

## Timing
- pred_taken: 0-cycle, combinational from fetch_pc/fetch_opcode and the current table.
- redirect, redirect_pc, res_taken: 1-cycle latency after res_valid. redirect is never high for two consecutive cycles unless res_valid is high on consecutive cycles with mispredicts.
- Table write takes effect at the edge. A same-cycle fetch lookup of the entry being updated returns the old value (no write-to-read bypass).
- Flags written at edge N are visible in flags_q from cycle N+1. Same-cycle flag use is served by the bypass.
- Reset (takes priority over all inputs at the edge, including mid-stream):
  - Every bht entry = 2^(CTR_W−1)−1 (weakly not-taken; 01 for CTR_W=2).
  - flags_q=0; redirect=0; res_taken=0; redirect_pc=0; n_branch=0; n_mispred=0.
  - A branch in res_valid during the reset cycle is dropped.
- Counter table reset may be implemented as a one-cycle parallel write; no multi-cycle init sweep.

## Test plan
- Reset, then fetch_pc=0x40 with bz → pred_taken=0; flags_q=0, redirect=0, stats=0.
- flag_we with Zero=1, then resolve bz at res_pc=0x40, res_pred=0, target 0x100 → next cycle redirect=1, redirect_pc=0x100, n_mispred=1, bht[0]=10 so pred_taken=1 at fetch 0x40.
- Same-cycle flag_we (Carry=1) and bncy resolve, res_pred=1, res_pc=0x80 → uses bypassed Carry=1; taken=0, redirect=1, redirect_pc=0x84.
- Resolve bnz taken four times at the same PC → counter saturates at 11; then one not-taken → 10, prediction stays 1.
- Unconditional 101011 with res_pred=1 → res_taken=1, redirect=0, table unchanged; non-branch opcode with res_valid → no stats change.
- Assert rst in the cycle after a mispredicting resolve → redirect drops to 0, all counters return to 01, statistics return to 0; redirect_pc near wrap (0xFFFFFFFC not-taken) yields 0x00000000.
